// File: rtl/fft_pkg.sv
// fft_pkg: shared types and helpers for the radix-2 DIT FFT address unit.
//   complex_16      : packed complex sample (16-bit signed real/imag).
//   fft_log2()      : constant function, ceil(log2(n)); exact for powers of 2.
//   fft_agu_state_t : sequencer states IDLE / ISSUE / DRAIN / DONE.
package fft_pkg;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } complex_16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fft_agu_state_t;

    function automatic int fft_log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_agu_pipe_if.sv
// fft_agu_pipe_if: control and address bus of the FFT address unit.
//   start/stall                  : requester -> AGU
//   busy/done/stage              : AGU status
//   rd_valid/rd_addr_a/b/tw_addr : butterfly read request
//   wr_valid/wr_addr_a/b         : butterfly write-back request
//   perf_cycles/perf_stalls      : only when FFT_AGU_PERF_EN is defined
// Modport master is the AGU side, slave the memory/controller side.
// N must match the N of the attached fft_agu_pipe.
interface fft_agu_pipe_if
    import fft_pkg::*;
#(
    parameter int N = 32
);
    localparam int L  = fft_log2(N);
    localparam int AW = L;
    localparam int SW = $clog2(L + 1);

    logic          start;
    logic          stall;
    logic          busy;
    logic          done;
    logic [SW-1:0] stage;
    logic          rd_valid;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [AW-2:0] tw_addr;
    logic          wr_valid;
    logic [AW-1:0] wr_addr_a;
    logic [AW-1:0] wr_addr_b;
`ifdef FFT_AGU_PERF_EN
    logic [31:0]   perf_cycles;
    logic [31:0]   perf_stalls;

    modport master (
        input  start, stall,
        output busy, done, stage, rd_valid, rd_addr_a, rd_addr_b, tw_addr,
               wr_valid, wr_addr_a, wr_addr_b, perf_cycles, perf_stalls
    );
    modport slave (
        output start, stall,
        input  busy, done, stage, rd_valid, rd_addr_a, rd_addr_b, tw_addr,
               wr_valid, wr_addr_a, wr_addr_b, perf_cycles, perf_stalls
    );
`else
    modport master (
        input  start, stall,
        output busy, done, stage, rd_valid, rd_addr_a, rd_addr_b, tw_addr,
               wr_valid, wr_addr_a, wr_addr_b
    );
    modport slave (
        output start, stall,
        input  busy, done, stage, rd_valid, rd_addr_a, rd_addr_b, tw_addr,
               wr_valid, wr_addr_a, wr_addr_b
    );
`endif
endinterface

// File: rtl/fft_addr_delay.sv
// fft_addr_delay: DEPTH-stage shift register with hold enable and async clear.
//   clk, rst_n : clock, asynchronous active-low clear
//   en_i       : shift when high, hold when low
//   d_i / q_o  : input word / word delayed by DEPTH enabled cycles
module fft_addr_delay #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] sr_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
        end else if (en_i) begin
            sr_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
        end
    end

    assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/fft_agu_pipe.sv
// fft_agu_pipe: address generator / sequencer for an in-place radix-2 DIT FFT.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fft_agu_pipe_if.master (start/stall in; status, read and
//                write-back addresses out)
// One butterfly read per unstalled ISSUE cycle, then BFLY_LAT DRAIN cycles so
// the last write of a stage lands before the first read of the next stage.
// Write addresses are the read addresses delayed by BFLY_LAT unstalled cycles.
// Optional macro FFT_AGU_PERF_EN adds perf_cycles / perf_stalls counters.
module fft_agu_pipe
    import fft_pkg::*;
#(
    parameter int N        = 32,
    parameter int BFLY_LAT = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    fft_agu_pipe_if.master bus
);
    localparam int L    = fft_log2(N);
    localparam int AW   = L;
    localparam int SW   = $clog2(L + 1);
    localparam int TW   = AW - 1;
    localparam int KW   = L - 1;
    localparam int HALF = N / 2;
    localparam int CW   = $clog2(BFLY_LAT + 1);
    localparam int DW   = 1 + 2 * AW;

    fft_agu_state_t state_q;
    logic [SW-1:0]  s_q, s_d;
    logic [KW-1:0]  k_q, k_d;
    logic [CW-1:0]  cnt_q;
    logic           busy_q, done_q, rdv_q;
    logic [AW-1:0]  ra_q, rb_q;
    logic [TW-1:0]  tw_q;
    logic [DW-1:0]  dl_d, dl_q;

    // Position of butterfly k inside its group of size 2*half at stage s.
    function automatic logic [AW-1:0] pos_of(input logic [SW-1:0] s, input logic [KW-1:0] k);
        return AW'(k) & ((AW'(1) << s) - AW'(1));
    endfunction

    // Top input: group index spread by 2*half, plus position in group.
    function automatic logic [AW-1:0] addr_a(input logic [SW-1:0] s, input logic [KW-1:0] k);
        return ((AW'(k) >> s) << (s + SW'(1))) | pos_of(s, k);
    endfunction

    function automatic logic [AW-1:0] addr_b(input logic [SW-1:0] s, input logic [KW-1:0] k);
        return addr_a(s, k) + (AW'(1) << s);
    endfunction

    function automatic logic [TW-1:0] tw_of(input logic [SW-1:0] s, input logic [KW-1:0] k);
        return TW'(pos_of(s, k) << (SW'(L - 1) - s));
    endfunction

    assign s_d = s_q + SW'(1);
    assign k_d = k_q + KW'(1);

    // Address outputs are registered and reloaded whenever a new butterfly
    // becomes current, so they hold through stalls and DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdv_q   <= 1'b0;
            ra_q    <= '0;
            rb_q    <= '0;
            tw_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= ISSUE;
                        s_q     <= '0;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        rdv_q   <= 1'b1;
                        ra_q    <= addr_a('0, '0);
                        rb_q    <= addr_b('0, '0);
                        tw_q    <= tw_of('0, '0);
                    end
                end
                ISSUE: begin
                    if (!bus.stall) begin
                        if (k_q == KW'(HALF - 1)) begin
                            state_q <= DRAIN;
                            cnt_q   <= '0;
                            rdv_q   <= 1'b0;
                        end else begin
                            k_q  <= k_d;
                            ra_q <= addr_a(s_q, k_d);
                            rb_q <= addr_b(s_q, k_d);
                            tw_q <= tw_of(s_q, k_d);
                        end
                    end
                end
                DRAIN: begin
                    if (!bus.stall) begin
                        if (cnt_q == CW'(BFLY_LAT - 1)) begin
                            if (s_q == SW'(L - 1)) begin
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ISSUE;
                                s_q     <= s_d;
                                k_q     <= '0;
                                rdv_q   <= 1'b1;
                                ra_q    <= addr_a(s_d, '0);
                                rb_q    <= addr_b(s_d, '0);
                                tw_q    <= tw_of(s_d, '0);
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                DONE: begin
                    // DONE ignores stall so the done pulse is never stretched.
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Only unstalled reads enter the delay line: rdv_q is sampled exactly
    // when the line shifts, so each issued read yields one write.
    assign dl_d = {rdv_q, ra_q, rb_q};

    fft_addr_delay #(
        .DEPTH (BFLY_LAT),
        .WIDTH (DW)
    ) u_wr_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (~bus.stall),
        .d_i   (dl_d),
        .q_o   (dl_q)
    );

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.stage     = s_q;
    assign bus.rd_valid  = rdv_q & ~bus.stall;
    assign bus.rd_addr_a = ra_q;
    assign bus.rd_addr_b = rb_q;
    assign bus.tw_addr   = tw_q;
    assign bus.wr_valid  = dl_q[DW-1] & ~bus.stall;
    assign bus.wr_addr_a = dl_q[2*AW-1:AW];
    assign bus.wr_addr_b = dl_q[AW-1:0];

`ifdef FFT_AGU_PERF_EN
    logic [31:0] perf_cycles_q, perf_stalls_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else if (state_q == IDLE && bus.start) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else if (busy_q) begin
            perf_cycles_q <= perf_cycles_q + 32'd1;
            if (bus.stall) perf_stalls_q <= perf_stalls_q + 32'd1;
        end
    end

    assign bus.perf_cycles = perf_cycles_q;
    assign bus.perf_stalls = perf_stalls_q;
`endif
endmodule

// File: tb/tb_fft_agu_pipe.sv
// Scoreboard bench for fft_agu_pipe (N=8, BFLY_LAT=3). The monitor pushes the
// full expected read/write sequence of a transform when it sees a start
// accepted, then pops and compares on every rd_valid / wr_valid.
module tb_fft_agu_pipe;
    localparam int N    = 8;
    localparam int LAT  = 3;
    localparam int L    = 3;
    localparam int HALF = N / 2;
    localparam int RUN  = 1 + L * (HALF + LAT);

    typedef struct {
        int s;
        int a;
        int b;
        int tw;
    } bfly_t;

    logic clk = 1'b0;
    logic rst_n;

    fft_agu_pipe_if #(.N(N)) bus ();

    fft_agu_pipe #(.N(N), .BFLY_LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared   = 0;
    int mismatched = 0;

    bfly_t exp_rd[$];
    bfly_t exp_wr[$];
    int    lat_q[$];

    bit active = 1'b0;
    int start_cyc = 0;
    int exp_done  = 0;
    int stall_cnt = 0;
    int uc        = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d at cycle %0d", name, got, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},     bus.busy, 0);
        chk({tag, "_done"},     bus.done, 0);
        chk({tag, "_stage"},    bus.stage, 0);
        chk({tag, "_rd_valid"}, bus.rd_valid, 0);
        chk({tag, "_rd_a"},     bus.rd_addr_a, 0);
        chk({tag, "_rd_b"},     bus.rd_addr_b, 0);
        chk({tag, "_tw"},       bus.tw_addr, 0);
        chk({tag, "_wr_valid"}, bus.wr_valid, 0);
        chk({tag, "_wr_a"},     bus.wr_addr_a, 0);
        chk({tag, "_wr_b"},     bus.wr_addr_b, 0);
`ifdef FFT_AGU_PERF_EN
        chk({tag, "_perf_cycles"}, bus.perf_cycles, 0);
        chk({tag, "_perf_stalls"}, bus.perf_stalls, 0);
`endif
    endtask

    // Reference: butterfly k of stage s pairs a and a+half where a is the
    // k-th index (in order) whose bit s is clear; twiddle W_N^(pos*N/2^(s+1)).
    task automatic load_model();
        exp_rd.delete();
        exp_wr.delete();
        lat_q.delete();
        for (int s = 0; s < L; s++) begin
            for (int k = 0; k < HALF; k++) begin
                bfly_t r;
                int half;
                half = 1 << s;
                r.s  = s;
                r.a  = (k / half) * 2 * half + (k % half);
                r.b  = r.a + half;
                r.tw = (k % half) * (N / (2 * half));
                exp_rd.push_back(r);
                exp_wr.push_back(r);
            end
        end
    endtask

    // Monitor / scoreboard: samples on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            active = 1'b0;
            exp_rd.delete();
            exp_wr.delete();
            lat_q.delete();
            chk_zero("reset");
        end else begin
            if (!bus.stall) uc++;
            if (bus.stall) begin
                chk("stall_rd_valid", bus.rd_valid, 0);
                chk("stall_wr_valid", bus.wr_valid, 0);
            end
            if (!active && bus.start) begin
                active    = 1'b1;
                start_cyc = cyc;
                exp_done  = cyc + RUN;
                stall_cnt = 0;
                load_model();
            end else if (active && cyc > start_cyc && cyc < exp_done && bus.stall) begin
                exp_done++;
                stall_cnt++;
            end
            chk("busy", bus.busy, (active && cyc > start_cyc && cyc < exp_done));
            chk("done", bus.done, (active && cyc == exp_done));
            if (bus.rd_valid) begin
                if (exp_rd.size() == 0) begin
                    chk("rd_unexpected", 1, 0);
                end else begin
                    bfly_t r;
                    r = exp_rd.pop_front();
                    chk("rd_stage", bus.stage, r.s);
                    chk("rd_a", bus.rd_addr_a, r.a);
                    chk("rd_b", bus.rd_addr_b, r.b);
                    chk("tw", bus.tw_addr, r.tw);
                    lat_q.push_back(uc);
                end
            end
            if (bus.wr_valid) begin
                if (exp_wr.size() == 0 || lat_q.size() == 0) begin
                    chk("wr_unexpected", 1, 0);
                end else begin
                    bfly_t w;
                    int u0;
                    w  = exp_wr.pop_front();
                    u0 = lat_q.pop_front();
                    chk("wr_a", bus.wr_addr_a, w.a);
                    chk("wr_b", bus.wr_addr_b, w.b);
                    chk("wr_latency", uc - u0, LAT);
                end
            end
            if (active && cyc == exp_done) begin
                chk("rd_left", exp_rd.size(), 0);
                chk("wr_left", exp_wr.size(), 0);
`ifdef FFT_AGU_PERF_EN
                chk("perf_cycles", bus.perf_cycles, exp_done - start_cyc - 1);
                chk("perf_stalls", bus.perf_stalls, stall_cnt);
`endif
                active = 1'b0;
            end
        end
    end

    task automatic pulse_start(output int sc);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        sc = cyc;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (active && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (active) begin
            compared++;
            mismatched++;
            $display("FAIL %s: transform still active after %0d cycles, expected idle", name, budget);
            active = 1'b0;
        end
    endtask

    initial begin
        int sc;
        int n;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Plain transform.
        pulse_start(sc);
        wait_idle("plain", 100);

        // Extra start while busy, 5-cycle stall inside stage 1 ISSUE.
        pulse_start(sc);
        at_cycle(sc + 3);  bus.start = 1'b1;
        at_cycle(sc + 4);  bus.start = 1'b0;
        at_cycle(sc + 9);  bus.stall = 1'b1;
        at_cycle(sc + 14); bus.stall = 1'b0;
        wait_idle("stall5", 100);

        // Asynchronous reset during stage 1 DRAIN.
        pulse_start(sc);
        at_cycle(sc + 13);
        #2 rst_n = 1'b0;
        #1 chk_zero("async");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Full transform after the abort.
        pulse_start(sc);
        wait_idle("after_reset", 100);

        // Random stalls and stray starts; first run stalls its first ISSUE cycle.
        for (int r = 0; r < 6; r++) begin
            bus.stall = (r == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            pulse_start(sc);
            n = 0;
            while (active && n < 400) begin
                @(posedge clk);
                #1;
                n++;
                bus.stall = ($urandom_range(0, 3) == 0);
                bus.start = ($urandom_range(0, 7) == 0);
            end
            bus.stall = 1'b0;
            bus.start = 1'b0;
            wait_idle("random", 100);
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
